sr_flag_arbiter: RTL and testbench
==================================

Name: sr_flag_arbiter

Overview:
- Shares a bank of NFLAG clocked NAND-style SR latches between NREQ requesters.
- Each requester asks for a set or clear of one flag; the arbiter grants round-robin and performs one operation at a time.
- Drives each latch's enable, s and r, and never presents the forbidden s=0/r=0 pattern.
- Keeps a registered mirror of the flag states, and initialises every latch to a known value after reset.

Parameters:
- NREQ, 4, number of requesters.
- NFLAG, 6, number of SR latches in the bank.
- IDX_W, 3, width of each flag index field.
- PULSE_CYC, 2, cycles lat_en is held high per latch write (must be ≥1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester request, held until ack.
- op  in  NREQ  per-requester operation: 1 = set flag (q→1), 0 = clear flag (q→0).
- idx  in  NREQ*IDX_W  per-requester flag index; requester i uses bits [i*IDX_W +: IDX_W].
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse alongside ack when the index was ≥ NFLAG.
- busy  out  1  high whenever state ≠ IDLE.
- lat_en  out  1  common latch enable; this is the latch clock input.
- lat_s  out  NFLAG  per-latch s input; active-low set.
- lat_r  out  NFLAG  per-latch r input; active-low clear.
- q  out  NFLAG  mirror of the latch states.

Behaviour:
- Latch encoding:
  - s=0, r=1 → q=1.
  - s=1, r=0 → q=0.
  - s=1, r=1 → hold.
  - s=0, r=0 → forbidden. Never driven on any bit in any cycle, including reset.
- All outputs are registered.
- Values during and immediately after rst:
  - lat_en=0, lat_s=all 1, lat_r=all 1.
  - ack=0, err=0, busy=1, q=0.
  - RR pointer=0.
  - state=INIT.
- INIT:
  - For PULSE_CYC cycles: lat_en=1, lat_r=all 0, lat_s=all 1, which clears every latch.
  - Then one cycle with lat_en=0 and lat_r still all 0.
  - Then → IDLE with lat_s and lat_r at all 1.
- IDLE:
  - If no req is set, stay.
  - Otherwise grant the first set req scanning upward from the RR pointer, modulo NREQ.
  - Capture the winner's id, op and idx. Set pointer = winner+1 mod NREQ.
  - idx ≥ NFLAG → ACK with err.
  - q[idx] already equals op → ACK with no latch activity (no-op).
  - Otherwise → DRIVE.
- DRIVE:
  - lat_en=1 for PULSE_CYC cycles.
  - Target bit only: set drives s=0, r=1; clear drives s=1, r=0.
  - All other bits stay at 1/1.
  - → GAP.
- GAP:
  - lat_en=0 for 1 cycle; pattern still held.
  - → ACK.
- ACK:
  - ack[winner]=1 for one cycle; err=1 if the index was invalid.
  - lat_s and lat_r return to all 1.
  - q[idx]=op is updated in this same cycle; q is not updated on err or no-op.
  - → IDLE.
- Latency, counted from the IDLE cycle that samples req:
  - Normal write: ack at cycle PULSE_CYC+2 (cycle 4 with defaults).
  - No-op or err: ack at cycle 1.
- Requester protocol:
  - Hold req, op and idx stable until ack is seen.
  - Drop req in the cycle ack is seen.
  - A req still high when IDLE next samples counts as a new request.
  - Changes to req, op or idx from non-winners during an operation are ignored until IDLE.
- busy=1 in INIT, DRIVE, GAP and ACK; busy=0 only in IDLE.
- Reset mid-operation:
  - Aborts the operation with no ack.
  - Next cycle shows the rst values, then INIT re-clears all latches.
  - The pointer returns to 0.
- Simultaneous requests on the same flag from different requesters are serialised in RR order; the last one to complete wins.

Test Plan:
- rst 1 cycle → lat_en high cycles 1–2 with lat_r=6'b000000 and lat_s=6'b111111. busy drops at cycle 4. q=0. No bit ever shows s=r=0.
- req[0]=1, op=1, idx=2 → lat_en=1 for 2 cycles with lat_s=6'b111011 and lat_r=6'b111111. ack[0] pulses 4 cycles after the grant cycle. q=6'b000100.
- req=4'b1111, all set with idx=0..3, each requester dropping req on its ack → grants in order 0,1,2,3; the next burst starts at requester 0. Final q=6'b001111.
- With q[2]=1, req[1] set idx=2 → ack[1] at cycle 1, lat_en stays 0, q unchanged. req[3] idx=7 → ack[3] and err at cycle 1, q unchanged.
- rst asserted during DRIVE → no ack. INIT reruns and q=0. A following request from requester 2 is granted only after busy=0.
- Two requesters target flag 5, requester 0 set and requester 1 clear, pointer=0 → set completes first, then clear. Final q[5]=0, with two acks 5 cycles apart.

Source files
------------

// File: rtl/sr_flag_arbiter_if.sv
// Requester and latch-bank signals of the SR flag arbiter.
// The master modport is the requester/bench side; the slave modport is the arbiter.
interface sr_flag_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 6,
    parameter int IDX_W = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       op;
    logic [NREQ*IDX_W-1:0] idx;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic                  busy;
    logic                  lat_en;
    logic [NFLAG-1:0]      lat_s;
    logic [NFLAG-1:0]      lat_r;
    logic [NFLAG-1:0]      q;

    modport master (
        output req, op, idx,
        input  ack, err, busy, lat_en, lat_s, lat_r, q
    );

    modport slave (
        input  req, op, idx,
        output ack, err, busy, lat_en, lat_s, lat_r, q
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that serialises set/clear requests onto a bank of
// NAND-style SR latches (active-low s/r) and keeps a registered mirror of their states.
module sr_flag_arbiter #(
    parameter int NREQ      = 4,
    parameter int NFLAG     = 6,
    parameter int IDX_W     = 3,
    parameter int PULSE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    sr_flag_arbiter_if.slave  bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(PULSE_CYC + 2);
    localparam logic [CNT_W-1:0] CNT_PULSE    = CNT_W'(PULSE_CYC);
    localparam logic [CNT_W-1:0] CNT_INIT_END = CNT_W'(PULSE_CYC + 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_DRIVE, S_GAP, S_ACK} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic             op_q, op_d;
    logic             bad_q, bad_d;
    logic [NFLAG-1:0] mask_q, mask_d;
    logic [NFLAG-1:0] q_q, q_d;

    logic             lat_en_q, lat_en_d;
    logic [NFLAG-1:0] lat_s_q, lat_s_d;
    logic [NFLAG-1:0] lat_r_q, lat_r_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic [IDX_W-1:0] idx_arr [NREQ];
    logic             found;
    logic [PTR_W-1:0] win;
    logic [PTR_W:0]   sum;
    logic [PTR_W:0]   ptr_sum;
    logic [IDX_W-1:0] idx_sel;
    logic             op_sel;
    logic             bad_sel;
    logic             noop_sel;
    logic [NFLAG-1:0] mask_sel;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            idx_arr[i] = bus.idx[i*IDX_W +: IDX_W];
        end
    end

    // First pending request at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
            if (!found && bus.req[sum[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_sum  = {1'b0, win} + (PTR_W+1)'(1);
        if (ptr_sum >= (PTR_W+1)'(NREQ)) ptr_sum = '0;
        idx_sel  = idx_arr[win];
        op_sel   = bus.op[win];
        bad_sel  = int'(idx_sel) >= NFLAG;
        mask_sel = bad_sel ? '0 : (NFLAG'(1) << idx_sel);
        noop_sel = ((q_q & mask_sel) != '0) == op_sel;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        bad_d   = bad_q;
        mask_d  = mask_q;
        q_d     = q_q;
        case (state_q)
            S_INIT: begin
                if (cnt_q == CNT_INIT_END) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (found) begin
                    win_d   = win;
                    op_d    = op_sel;
                    bad_d   = bad_sel;
                    mask_d  = mask_sel;
                    ptr_d   = ptr_sum[PTR_W-1:0];
                    if (bad_sel || noop_sel) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_DRIVE;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == CNT_PULSE) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                state_d = S_ACK;
                q_d     = op_q ? (q_q | mask_q) : (q_q & ~mask_q);
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        lat_en_d = 1'b0;
        lat_s_d  = '1;
        lat_r_d  = '1;
        ack_d    = '0;
        err_d    = 1'b0;
        busy_d   = 1'b1;
        case (state_d)
            S_INIT: begin
                if (cnt_d != '0) lat_r_d = '0;
                if (cnt_d != '0 && cnt_d <= CNT_PULSE) lat_en_d = 1'b1;
            end
            S_IDLE: busy_d = 1'b0;
            S_DRIVE, S_GAP: begin
                lat_en_d = (state_d == S_DRIVE);
                if (op_d) lat_s_d = ~mask_d;
                else      lat_r_d = ~mask_d;
            end
            S_ACK: begin
                ack_d = NREQ'(1) << win_d;
                err_d = bad_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            ptr_q    <= '0;
            q_q      <= '0;
            lat_en_q <= 1'b0;
            lat_s_q  <= '1;
            lat_r_q  <= '1;
            ack_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            q_q      <= q_d;
            lat_en_q <= lat_en_d;
            lat_s_q  <= lat_s_d;
            lat_r_q  <= lat_r_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        win_q  <= win_d;
        op_q   <= op_d;
        bad_q  <= bad_d;
        mask_q <= mask_d;
    end

    assign bus.lat_en = lat_en_q;
    assign bus.lat_s  = lat_s_q;
    assign bus.lat_r  = lat_r_q;
    assign bus.ack    = ack_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.q      = q_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: init sequence, writes, round-robin order,
// no-op/error requests, reset abort and same-flag serialisation.
module tb_sr_flag_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   forbid_cnt = 0;
    logic [3:0] a;
    int   n;

    sr_flag_arbiter_if #(.NREQ(4), .NFLAG(6), .IDX_W(3)) bus ();

    sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDX_W(3), .PULSE_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Any bit with s and r both low is the forbidden latch input.
    always @(negedge clk) begin
        if ((~bus.lat_s & ~bus.lat_r) != 6'b0) forbid_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic o, input logic [2:0] ix);
        bus.req[i] = 1'b1;
        bus.op[i]  = o;
        bus.idx[i*3 +: 3] = ix;
    endtask

    task automatic wait_ack(output logic [3:0] ack_seen, output int cyc);
        ack_seen = 4'b0;
        cyc = 0;
        while (cyc < 12) begin
            tick();
            cyc++;
            if (bus.ack != 4'b0) begin
                ack_seen = bus.ack;
                break;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        bus.op  = '0;
        bus.idx = '0;

        // Reset values and the INIT clearing sequence.
        tick();
        chk("rst_lat_en", bus.lat_en, 0);
        chk("rst_lat_s", bus.lat_s, 6'h3f);
        chk("rst_lat_r", bus.lat_r, 6'h3f);
        chk("rst_ack", bus.ack, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 1);
        chk("rst_q", bus.q, 0);
        rst = 1'b0;
        tick();
        chk("init1_lat_en", bus.lat_en, 1);
        chk("init1_lat_r", bus.lat_r, 0);
        chk("init1_lat_s", bus.lat_s, 6'h3f);
        tick();
        chk("init2_lat_en", bus.lat_en, 1);
        chk("init2_lat_r", bus.lat_r, 0);
        tick();
        chk("init3_lat_en", bus.lat_en, 0);
        chk("init3_lat_r", bus.lat_r, 0);
        chk("init3_busy", bus.busy, 1);
        tick();
        chk("init4_busy", bus.busy, 0);
        chk("init4_lat_r", bus.lat_r, 6'h3f);
        chk("init4_q", bus.q, 0);

        // Single set of flag 2 from requester 0.
        set_req(0, 1'b1, 3'd2);
        tick();
        chk("wr1_lat_en", bus.lat_en, 1);
        chk("wr1_lat_s", bus.lat_s, 6'h3b);
        chk("wr1_lat_r", bus.lat_r, 6'h3f);
        chk("wr1_busy", bus.busy, 1);
        tick();
        chk("wr2_lat_en", bus.lat_en, 1);
        chk("wr2_ack", bus.ack, 0);
        tick();
        chk("wr3_lat_en", bus.lat_en, 0);
        chk("wr3_lat_s", bus.lat_s, 6'h3b);
        tick();
        chk("wr4_ack", bus.ack, 4'b0001);
        chk("wr4_err", bus.err, 0);
        chk("wr4_q", bus.q, 6'h04);
        chk("wr4_lat_s", bus.lat_s, 6'h3f);
        bus.req[0] = 1'b0;
        tick();
        chk("wr5_ack", bus.ack, 0);
        chk("wr5_busy", bus.busy, 0);

        // No-op on an already-set flag, then an out-of-range index.
        set_req(1, 1'b1, 3'd2);
        tick();
        chk("noop_ack", bus.ack, 4'b0010);
        chk("noop_err", bus.err, 0);
        chk("noop_lat_en", bus.lat_en, 0);
        chk("noop_q", bus.q, 6'h04);
        bus.req[1] = 1'b0;
        tick();
        chk("noop_busy", bus.busy, 0);
        set_req(3, 1'b1, 3'd7);
        tick();
        chk("bad_ack", bus.ack, 4'b1000);
        chk("bad_err", bus.err, 1);
        chk("bad_lat_en", bus.lat_en, 0);
        chk("bad_q", bus.q, 6'h04);
        bus.req[3] = 1'b0;
        tick();
        chk("bad_err_clr", bus.err, 0);
        chk("bad_busy", bus.busy, 0);

        // All four request at once; pointer is back at 0. Requester 2 is a no-op.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i));
        for (int g = 0; g < 4; g++) begin
            wait_ack(a, n);
            chk($sformatf("rr_ack%0d", g), a, 32'(4'b0001 << g));
            chk($sformatf("rr_lat%0d", g), n, (g == 0) ? 4 : ((g == 2) ? 2 : 5));
            bus.req[g] = 1'b0;
        end
        tick();
        chk("rr_q", bus.q, 6'h0f);
        chk("rr_busy", bus.busy, 0);

        // Next burst starts again at requester 0.
        set_req(0, 1'b1, 3'd0);
        set_req(3, 1'b1, 3'd3);
        wait_ack(a, n);
        chk("burst2_first", a, 4'b0001);
        chk("burst2_lat", n, 1);
        bus.req[0] = 1'b0;
        wait_ack(a, n);
        chk("burst2_second", a, 4'b1000);
        bus.req[3] = 1'b0;
        tick();

        // Reset during DRIVE aborts the write and reruns INIT.
        set_req(0, 1'b1, 3'd4);
        tick();
        chk("abort_drive", bus.lat_en, 1);
        rst = 1'b1;
        bus.req[0] = 1'b0;
        set_req(2, 1'b1, 3'd1);
        tick();
        chk("abort_ack", bus.ack, 0);
        chk("abort_lat_en", bus.lat_en, 0);
        chk("abort_lat_r", bus.lat_r, 6'h3f);
        chk("abort_busy", bus.busy, 1);
        chk("abort_q", bus.q, 0);
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("reinit%0d_ack", c), bus.ack, 0);
            chk($sformatf("reinit%0d_busy", c), bus.busy, 1);
        end
        tick();
        chk("reinit4_busy", bus.busy, 0);
        chk("reinit4_q", bus.q, 0);
        wait_ack(a, n);
        chk("post_rst_ack", a, 4'b0100);
        chk("post_rst_lat", n, 4);
        chk("post_rst_q", bus.q, 6'h02);
        bus.req[2] = 1'b0;

        // Same flag from two requesters: set then clear, last one wins.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("same_idle", bus.busy, 0);
        set_req(0, 1'b1, 3'd5);
        set_req(1, 1'b0, 3'd5);
        wait_ack(a, n);
        chk("same_first", a, 4'b0001);
        chk("same_first_lat", n, 4);
        chk("same_first_q", bus.q, 6'h20);
        bus.req[0] = 1'b0;
        wait_ack(a, n);
        chk("same_second", a, 4'b0010);
        chk("same_gap", n, 5);
        chk("same_final_q", bus.q, 6'h00);
        bus.req[1] = 1'b0;
        tick();

        chk("forbidden_sr", forbid_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
